// File: rtl/coffee_machine_ctrl_if.sv
// User-input / status bundle between the panel logic and the coffee recipe sequencer.
// The panel drives start/selector; the sequencer returns its state code and done flag.
interface coffee_machine_ctrl_if;
  logic       start;
  logic [1:0] coffee_sel;
  logic [2:0] state;
  logic       done;

  modport master (output start, output coffee_sel, input state, input done);
  modport slave  (input start, input coffee_sel, output state, output done);
endinterface

// File: rtl/coffee_machine_ctrl.sv
// Tick-driven recipe sequencer: a DIV-cycle clock-enable paces the stages of the latched recipe.
// Start is captured within one clk edge in IDLE; departure waits for the next tick (1..DIV cycles); no backpressure.
module coffee_machine_ctrl #(
  parameter int unsigned DIV      = 50000000,
  parameter int unsigned T_AGUA   = 3,
  parameter int unsigned T_CAFE   = 2,
  parameter int unsigned T_LECHE  = 2,
  parameter int unsigned T_AZUCAR = 1,
  parameter int unsigned T_CREMA  = 2,
  parameter int unsigned T_END    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  coffee_machine_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AGUA   = 3'd1,
    S_CAFE   = 3'd2,
    S_LECHE  = 3'd3,
    S_AZUCAR = 3'd4,
    S_CREMA  = 3'd5,
    S_END    = 3'd6
  } state_t;

  localparam logic [31:0] DIV_M1 = 32'(DIV - 1);

  logic [31:0] cnt;
  logic        tick;
  state_t      state_q;
  logic        done_q;
  logic [3:0]  timer;
  logic        pending;
  logic [1:0]  recipe;

  assign tick      = ~reset & (cnt == DIV_M1);
  assign bus.state = state_q;
  assign bus.done  = done_q;

  function automatic logic [3:0] dwell(input state_t s);
    case (s)
      S_AGUA:   dwell = 4'(T_AGUA);
      S_CAFE:   dwell = 4'(T_CAFE);
      S_LECHE:  dwell = 4'(T_LECHE);
      S_AZUCAR: dwell = 4'(T_AZUCAR);
      S_CREMA:  dwell = 4'(T_CREMA);
      S_END:    dwell = 4'(T_END);
      default:  dwell = 4'd1;
    endcase
  endfunction

  // Recipe only matters at the CAFE and LECHE branch points.
  function automatic state_t next_of(input state_t s, input logic [1:0] r);
    case (s)
      S_AGUA:   next_of = S_CAFE;
      S_CAFE:   next_of = (r == 2'b00) ? S_END : S_LECHE;
      S_LECHE:  next_of = (r == 2'b01) ? S_AZUCAR : S_CREMA;
      S_AZUCAR: next_of = S_END;
      S_CREMA:  next_of = S_END;
      default:  next_of = S_IDLE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      timer   <= '0;
      pending <= 1'b0;
      recipe  <= 2'b00;
    end else begin
      cnt <= tick ? '0 : cnt + 32'd1;

      // Capture beats a same-edge tick: pending was 0, so the IDLE branch below stays put.
      if (state_q == S_IDLE && !pending && bus.start) begin
        pending <= 1'b1;
        recipe  <= bus.coffee_sel;
      end

      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (pending) begin
              pending <= 1'b0;
              if (recipe != 2'b11) begin
                state_q <= S_AGUA;
                timer   <= '0;
              end
            end
          end
          S_AGUA, S_CAFE, S_LECHE, S_AZUCAR, S_CREMA, S_END: begin
            if (timer == dwell(state_q) - 4'd1) begin
              state_q <= next_of(state_q, recipe);
              timer   <= '0;
              done_q  <= (next_of(state_q, recipe) == S_END);
            end else begin
              timer <= timer + 4'd1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            timer   <= '0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coffee_machine_ctrl.sv
// Scoreboard bench for coffee_machine_ctrl at DIV=4: stimulus queues expected state changes,
// a negedge monitor checks each change's code, done level and elapsed clk cycles.
module tb_coffee_machine_ctrl;
  localparam int DIV = 4;

  typedef struct {
    int st;
    int dn;
    int dmin;
    int dmax;
    bit use_ref;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   ref_cyc = 0;
  int   last_cyc = 0;
  int   prev_st = 0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  coffee_machine_ctrl_if bus ();

  coffee_machine_ctrl #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Monitor: every state change must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && int'(bus.state) != prev_st) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: state %0d -> %0d with nothing expected (cycle %0d)",
                 prev_st, bus.state, cyc);
      end else begin
        exp_t e;
        int   d;
        e = q.pop_front();
        d = e.use_ref ? (cyc - ref_cyc) : (cyc - last_cyc);
        check("state", int'(bus.state), e.st);
        check("done", int'(bus.done), e.dn);
        check_rng("dwell_cycles", d, e.dmin, e.dmax);
      end
      prev_st  = int'(bus.state);
      last_cyc = cyc;
    end
  end

  task automatic push(input int st, input int dn, input int dmin, input int dmax, input bit use_ref);
    exp_t e;
    e.st = st; e.dn = dn; e.dmin = dmin; e.dmax = dmax; e.use_ref = use_ref;
    q.push_back(e);
  endtask

  // One-cycle start pulse; AGUA must follow 1..DIV edges after the capture edge.
  task automatic pulse_start(input logic [1:0] sel);
    @(negedge clk);
    bus.coffee_sel = sel;
    bus.start = 1'b1;
    ref_cyc = cyc;
    if (sel != 2'b11) push(1, 0, 2, DIV + 1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(bus.state) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(bus.state) != s) begin
      checks++;
      errors++;
      $display("FAIL wait_state: got %0d expected %0d after %0d cycles", bus.state, s, budget);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q.size(), 0);
    repeat (2 * DIV) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.coffee_sel = 2'b00;

    repeat (10) @(negedge clk);
    reset = 1'b0;
    check("reset_state", int'(bus.state), 0);
    check("reset_done", int'(bus.done), 0);
    prev_st = 0;
    last_cyc = cyc;
    mon_en = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_no_start", int'(bus.state), 0);

    // Espresso: AGUA 12, CAFE 8, END 4 clk.
    pulse_start(2'b00);
    push(2, 0, 12, 12, 1'b0);
    push(6, 1, 8, 8, 1'b0);
    push(0, 0, 4, 4, 1'b0);
    drain(200);

    // Latte.
    pulse_start(2'b01);
    push(2, 0, 12, 12, 1'b0);
    push(3, 0, 8, 8, 1'b0);
    push(4, 0, 8, 8, 1'b0);
    push(6, 1, 4, 4, 1'b0);
    push(0, 0, 4, 4, 1'b0);
    drain(300);

    // Cappuccino with selector flipped after capture.
    pulse_start(2'b10);
    push(2, 0, 12, 12, 1'b0);
    push(3, 0, 8, 8, 1'b0);
    push(5, 0, 8, 8, 1'b0);
    push(6, 1, 8, 8, 1'b0);
    push(0, 0, 4, 4, 1'b0);
    wait_state(1, 50);
    bus.coffee_sel = 2'b00;
    drain(300);

    // Invalid recipe: no departure expected.
    pulse_start(2'b11);
    repeat (4 * DIV) @(negedge clk);
    check("invalid_stays_idle", int'(bus.state), 0);

    // Espresso with a start pulse during CAFE that must be ignored.
    pulse_start(2'b00);
    push(2, 0, 12, 12, 1'b0);
    push(6, 1, 8, 8, 1'b0);
    push(0, 0, 4, 4, 1'b0);
    wait_state(2, 100);
    bus.coffee_sel = 2'b01;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.coffee_sel = 2'b00;
    drain(200);
    repeat (4 * DIV) @(negedge clk);
    check("ignored_start_idle", int'(bus.state), 0);

    // Latte aborted by reset in LECHE, then a clean espresso.
    pulse_start(2'b01);
    push(2, 0, 12, 12, 1'b0);
    push(3, 0, 8, 8, 1'b0);
    wait_state(3, 200);
    reset = 1'b1;
    ref_cyc = cyc;
    push(0, 0, 1, 1, 1'b1);
    @(negedge clk);
    check("reset_mid_done", int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;
    drain(50);
    pulse_start(2'b00);
    push(2, 0, 12, 12, 1'b0);
    push(6, 1, 8, 8, 1'b0);
    push(0, 0, 4, 4, 1'b0);
    drain(200);

    check("final_state", int'(bus.state), 0);
    check("final_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
